// File: rtl/i2c_target_regs_if.sv
// Write-strobe and status bundle of the I2C register target.
// The target drives it through master; observers use slave.
interface i2c_target_regs_if;
    logic        wr_valid;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        output busy
    );

    modport slave (
        input wr_valid,
        input wr_addr,
        input wr_data,
        input busy
    );
endinterface

// File: rtl/i2c_target_regs.sv
// SCCB/I2C target: 16-bit register address, 8-bit data, burst r/w.
// Small byte register file; every accepted write is strobed out.
module i2c_target_regs #(
    parameter logic [6:0] DEV_ADDR       = 7'h3C,
    parameter int         REG_DEPTH_LOG2 = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              scl,
    inout  wire               sda,
    i2c_target_regs_if.master wr
);
    localparam int DEPTH = 1 << REG_DEPTH_LOG2;

    typedef enum logic [3:0] {
        IDLE, DEV, ACK_DEV, REG_HI, ACK_HI, REG_LO,
        ACK_LO, WDATA, ACK_W, RDATA, RACK, IGNORE
    } state_t;

    state_t      state_q, state_d;
    logic        scl_s1_q, scl_s2_q, scl_p_q;
    logic        sda_s1_q, sda_s2_q, sda_p_q;
    logic [3:0]  cnt_q, cnt_d;
    logic [6:0]  sh_q, sh_d;
    logic [7:0]  tx_q, tx_d;
    logic [15:0] ptr_q, ptr_d;
    logic        rw_q, rw_d;
    logic        drv_q, drv_d;
    logic        oe_q;
    logic        busy_q, busy_d;
    logic        wv_q, wv_d;
    logic [15:0] wa_q, wa_d;
    logic [7:0]  wd_q, wd_d;
    logic        mem_we;
    logic [7:0]  mem_q [DEPTH];

    logic        scl_rise, scl_fall, start, stop;
    logic [7:0]  byte_in;
    logic [7:0]  rd_byte;
    logic        last_bit;
    logic [REG_DEPTH_LOG2-1:0] idx;

    assign scl_rise = scl_s2_q & ~scl_p_q;
    assign scl_fall = ~scl_s2_q & scl_p_q;
    assign start    = scl_s2_q & scl_p_q & sda_p_q & ~sda_s2_q;
    assign stop     = scl_s2_q & scl_p_q & ~sda_p_q & sda_s2_q;
    assign byte_in  = {sh_q, sda_s2_q};
    assign last_bit = (cnt_q == 4'd7);
    assign idx      = ptr_q[REG_DEPTH_LOG2-1:0];
    assign rd_byte  = mem_q[idx];

    assign sda         = oe_q ? 1'b0 : 1'bz;
    assign wr.wr_valid = wv_q;
    assign wr.wr_addr  = wa_q;
    assign wr.wr_data  = wd_q;
    assign wr.busy     = busy_q;

    // Two-flop pin synchronisers plus previous sample for edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            scl_p_q  <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
            sda_p_q  <= 1'b1;
        end else begin
            scl_s1_q <= scl;
            scl_s2_q <= scl_s1_q;
            scl_p_q  <= scl_s2_q;
            sda_s1_q <= sda;
            sda_s2_q <= sda_s1_q;
            sda_p_q  <= sda_s2_q;
        end
    end

    // Bus FSM: bit/byte sequencing, pointer, ACK and read-data drive.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        tx_d    = tx_q;
        ptr_d   = ptr_q;
        rw_d    = rw_q;
        drv_d   = drv_q;
        busy_d  = busy_q;
        wv_d    = 1'b0;
        wa_d    = wa_q;
        wd_d    = wd_q;
        mem_we  = 1'b0;
        if (stop) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
            drv_d   = 1'b0;
            busy_d  = 1'b0;
        end else if (start) begin
            state_d = DEV;
            cnt_d   = 4'd0;
            drv_d   = 1'b0;
            busy_d  = 1'b1;
        end else begin
            unique case (state_q)
                DEV, REG_HI, REG_LO, WDATA: begin
                    if (scl_rise) begin
                        sh_d  = byte_in[6:0];
                        cnt_d = cnt_q + 4'd1;
                        if (last_bit) begin
                            cnt_d = 4'd0;
                            unique case (state_q)
                                DEV: begin
                                    if (byte_in[7:1] == DEV_ADDR) begin
                                        state_d = ACK_DEV;
                                        rw_d    = byte_in[0];
                                    end else begin
                                        state_d = IGNORE;
                                    end
                                end
                                REG_HI: begin
                                    ptr_d[15:8] = byte_in;
                                    state_d     = ACK_HI;
                                end
                                REG_LO: begin
                                    ptr_d[7:0] = byte_in;
                                    state_d    = ACK_LO;
                                end
                                default: begin
                                    mem_we  = 1'b1;
                                    wv_d    = 1'b1;
                                    wa_d    = ptr_q;
                                    wd_d    = byte_in;
                                    ptr_d   = ptr_q + 16'd1;
                                    state_d = ACK_W;
                                end
                            endcase
                        end
                    end
                end
                ACK_DEV, ACK_HI, ACK_LO, ACK_W: begin
                    if (scl_fall) begin
                        if (!drv_q) begin
                            drv_d = 1'b1;
                        end else begin
                            drv_d = 1'b0;
                            cnt_d = 4'd0;
                            unique case (state_q)
                                ACK_DEV: begin
                                    if (rw_q) begin
                                        state_d = RDATA;
                                        tx_d    = rd_byte;
                                        drv_d   = ~rd_byte[7];
                                        cnt_d   = 4'd1;
                                    end else begin
                                        state_d = REG_HI;
                                    end
                                end
                                ACK_HI:  state_d = REG_LO;
                                default: state_d = WDATA;
                            endcase
                        end
                    end
                end
                RDATA: begin
                    if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            drv_d   = 1'b0;
                            cnt_d   = 4'd0;
                            state_d = RACK;
                        end else begin
                            tx_d  = {tx_q[6:0], tx_q[7]};
                            drv_d = ~tx_q[6];
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                end
                RACK: begin
                    if (scl_rise) begin
                        if (sda_s2_q) begin
                            state_d = IGNORE;
                        end else begin
                            ptr_d = ptr_q + 16'd1;
                            cnt_d = 4'd9;
                        end
                    end else if (scl_fall && cnt_q == 4'd9) begin
                        state_d = RDATA;
                        tx_d    = rd_byte;
                        drv_d   = ~rd_byte[7];
                        cnt_d   = 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // State and datapath registers; sda enable lags the decision 1 clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            sh_q    <= 7'd0;
            tx_q    <= 8'd0;
            ptr_q   <= 16'd0;
            rw_q    <= 1'b0;
            drv_q   <= 1'b0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            wv_q    <= 1'b0;
            wa_q    <= 16'd0;
            wd_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
            ptr_q   <= ptr_d;
            rw_q    <= rw_d;
            drv_q   <= drv_d;
            oe_q    <= drv_q;
            busy_q  <= busy_d;
            wv_q    <= wv_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
        end
    end

    // Register file, cleared on reset, written on each accepted byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'd0;
            end
        end else if (mem_we) begin
            mem_q[idx] <= byte_in;
        end
    end
endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged initiator, array model.
// Directed protocol cases followed by randomized burst write/read.
module tb_i2c_target_regs;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic scl = 1'b1;
    logic sda_low = 1'b0;
    wire  sda;

    int ncmp = 0;
    int nfail = 0;

    i2c_target_regs_if bus ();

    i2c_target_regs dut (
        .clk   (clk),
        .rst_n (rst_n),
        .scl   (scl),
        .sda   (sda),
        .wr    (bus)
    );

    assign sda = sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    logic [23:0] ev [1024];
    int nev = 0;
    int tgt_low = 0;

    always @(negedge clk) begin
        #2;
        if (bus.wr_valid === 1'b1) begin
            ev[nev % 1024] = {bus.wr_addr, bus.wr_data};
            nev = nev + 1;
        end
        if (sda === 1'b0 && !sda_low) tgt_low = tgt_low + 1;
    end

    logic [7:0] mm [64];
    logic [7:0] dq [$];
    logic [7:0] rq [$];

    initial begin
        #3000000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wq();
        repeat (5) @(negedge clk);
    endtask

    task automatic bit_x(input logic b, output logic r);
        sda_low = ~b;
        wq();
        scl = 1'b1;
        wq();
        r = sda;
        wq();
        scl = 1'b0;
        wq();
    endtask

    task automatic i2c_start();
        sda_low = 1'b0;
        wq();
        scl = 1'b1;
        wq();
        sda_low = 1'b1;
        wq();
        scl = 1'b0;
        wq();
    endtask

    task automatic i2c_stop(input bit chk);
        sda_low = 1'b1;
        wq();
        scl = 1'b1;
        wq();
        sda_low = 1'b0;
        if (chk) begin
            repeat (2) @(posedge clk);
            #1 check("busy_hold", bus.busy, 1);
            @(posedge clk);
            #1 check("busy_fall", bus.busy, 0);
        end
        wq();
        wq();
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_x(b[i], r);
        bit_x(1'b1, r);
        ack = ~r;
    endtask

    task automatic rd_byte(input logic nack, output logic [7:0] b);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_x(1'b1, r);
            b[i] = r;
        end
        bit_x(nack, r);
    endtask

    task automatic set_ptr(input logic [15:0] a);
        logic ack;
        i2c_start();
        wr_byte(8'h78, ack);
        check("ack_dev_w", ack, 1);
        wr_byte(a[15:8], ack);
        check("ack_hi", ack, 1);
        wr_byte(a[7:0], ack);
        check("ack_lo", ack, 1);
    endtask

    task automatic write_txn(input logic [15:0] a, input bit chk);
        logic ack;
        int n0;
        int ai;
        n0 = nev;
        set_ptr(a);
        for (int i = 0; i < dq.size(); i++) begin
            wr_byte(dq[i], ack);
            check("ack_data", ack, 1);
        end
        i2c_stop(chk);
        check("wr_count", nev - n0, dq.size());
        for (int i = 0; i < dq.size(); i++) begin
            ai = (int'(a) + i) % 65536;
            mm[ai % 64] = dq[i];
            check("wr_event", ev[(n0 + i) % 1024], {ai[15:0], dq[i]});
        end
    endtask

    task automatic read_txn(input logic [15:0] a, input int n);
        logic ack;
        logic [7:0] b;
        int n0;
        n0 = nev;
        rq.delete();
        set_ptr(a);
        i2c_start();
        wr_byte(8'h79, ack);
        check("ack_dev_r", ack, 1);
        for (int i = 0; i < n; i++) begin
            rd_byte(i == n - 1, b);
            rq.push_back(b);
            check("rd_data", b, mm[(int'(a) + i) % 64]);
        end
        check("rel_nack", sda, 1);
        i2c_stop(1'b0);
        check("rd_no_wr", nev - n0, 0);
    endtask

    initial begin
        logic ack;
        logic r;
        logic [15:0] a;
        int len;
        int t0;
        int n0;

        for (int i = 0; i < 64; i++) mm[i] = 8'h00;
        repeat (4) @(negedge clk);
        check("rst_sda", sda, 1);
        check("rst_wv", bus.wr_valid, 0);
        check("rst_wa", bus.wr_addr, 0);
        check("rst_wd", bus.wr_data, 0);
        check("rst_busy", bus.busy, 0);
        rst_n = 1'b1;
        wq();

        dq.delete();
        dq.push_back(8'h82);
        write_txn(16'h3008, 1'b1);

        dq.delete();
        dq.push_back(8'h11);
        dq.push_back(8'h22);
        dq.push_back(8'h33);
        write_txn(16'h303F, 1'b0);
        read_txn(16'h303F, 3);

        read_txn(16'h3008, 2);
        check("rand_rd_b0", rq[0], 8'h82);

        t0 = tgt_low;
        n0 = nev;
        i2c_start();
        wr_byte(8'h42, ack);
        check("nack_dev", ack, 0);
        wr_byte(8'h00, ack);
        wr_byte(8'h00, ack);
        wr_byte(8'h55, ack);
        check("nack_data", ack, 0);
        i2c_stop(1'b0);
        check("wrong_no_drive", tgt_low - t0, 0);
        check("wrong_no_wr", nev - n0, 0);
        read_txn(16'h0000, 1);
        check("wrong_mem0", rq[0], 8'h22);

        n0 = nev;
        set_ptr(16'h3008);
        for (int i = 0; i < 4; i++) bit_x(i[0], r);
        i2c_stop(1'b0);
        check("part_no_wr", nev - n0, 0);
        check("part_idle", bus.busy, 0);
        dq.delete();
        dq.push_back(8'($urandom));
        write_txn(16'h3008, 1'b0);
        read_txn(16'h3008, 1);

        for (int it = 0; it < 6; it++) begin
            a = (it == 0) ? 16'hFFFE : 16'($urandom);
            len = (it == 0) ? 3 : $urandom_range(1, 4);
            dq.delete();
            for (int j = 0; j < len; j++) dq.push_back(8'($urandom));
            write_txn(a, 1'b0);
            read_txn(a, len);
        end

        dq.delete();
        dq.push_back(8'h82);
        write_txn(16'h3008, 1'b0);
        set_ptr(16'h3008);
        i2c_start();
        wr_byte(8'h79, ack);
        check("ack_dev_r", ack, 1);
        bit_x(1'b1, r);
        check("rd_msb", r, 1);
        check("rd_drive", sda, 0);
        rst_n = 1'b0;
        #1;
        check("arst_sda", sda, 1);
        check("arst_wv", bus.wr_valid, 0);
        check("arst_wa", bus.wr_addr, 0);
        check("arst_wd", bus.wr_data, 0);
        check("arst_busy", bus.busy, 0);
        for (int i = 0; i < 64; i++) mm[i] = 8'h00;
        scl = 1'b1;
        wq();
        rst_n = 1'b1;
        wq();
        read_txn(16'h3008, 1);
        check("arst_mem", rq[0], 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/i2c_target_regs.md
# i2c_target_regs

I2C target (responder) that models the camera sensor side of the SCCB/I2C configuration bus. It answers the 16-bit-register-address, 8-bit-data transactions our configuration initiator issues, stores written bytes in a small register file, and returns them on reads. It gives the configuration path a closed-loop bench and on-chip loopback partner, and reports every accepted write on a strobe port.

## Interface
- DEV_ADDR, 7'h3C: 7-bit target address; 8-bit write/read bytes are 0x78/0x79.
- REG_DEPTH_LOG2, 6: register file holds 2^REG_DEPTH_LOG2 bytes, indexed by reg_ptr[REG_DEPTH_LOG2-1:0].

- clk  in  1  system clock; must be ≥ 8× SCL rate, and each SCL high/low phase must be ≥ 4 clk.
- rst_n  in  1  asynchronous, active-low reset.
- scl  in  1  bus clock; the target never stretches it.
- sda  inout  1  open-drain: drives 1'b0 or 1'bz, never 1'b1.
- wr_valid  out  1  one-cycle pulse per accepted data byte.
- wr_addr  out  16  register address of that byte.
- wr_data  out  8  the byte.
- busy  out  1  high from START to STOP.

## Operation
- scl/sda pass through 2-flop synchronisers, then a registered edge detect. START = sda fall while scl high. STOP = sda rise while scl high. Data bits are sampled on scl rise. sda drive changes only on scl fall.
- State machine states: IDLE, DEV, ACK_DEV, REG_HI, ACK_HI, REG_LO, ACK_LO, WDATA, ACK_W, RDATA, RACK, IGNORE.
- START from any state goes to DEV, clears the bit counter and asserts busy. A repeated START keeps reg_ptr.
- DEV: shift in 8 bits.
  - Match ({DEV_ADDR,0}) → ACK_DEV, then REG_HI.
  - Match ({DEV_ADDR,1}) → ACK_DEV, then RDATA.
  - Mismatch → IGNORE. No ACK is given; sda stays released.
- ACK_*: on the scl fall after bit 8, drive sda low. On the next scl fall, release sda and enter the next state.
- REG_HI/REG_LO: bytes load reg_ptr[15:8] and reg_ptr[7:0]. ACK_LO → WDATA.
- WDATA: after bit 8 the target writes mem[index] and pulses wr_valid with wr_addr=reg_ptr and wr_data=byte. reg_ptr then increments, wrapping 0xFFFF→0x0000, and the state goes to ACK_W then WDATA (burst write).
- RDATA: on the scl fall that ends ACK_DEV or RACK, load mem[index] and drive the MSB. Shift on each later scl fall; a 1 bit means release. Release after bit 8, then go to RACK.
- RACK: sample the initiator's ACK on scl rise.
  - 0 → reg_ptr++ and send the next byte.
  - 1 (NACK) → IGNORE with sda released.
- IGNORE: sda is released; only START or STOP is acted on.
- STOP from any state → IDLE with sda released and busy low. A partial byte is discarded: no memory write, no wr_valid.
- Reset values: sda=z, wr_valid=0, wr_addr=0, wr_data=0, busy=0, reg_ptr=0, state IDLE, all memory bytes 0x00.
- Reset mid-transaction releases sda at once, asynchronously.

## Timing
- Bus-event recognition latency is 3 clk from a pin edge (2 sync + 1 edge register).
- An sda drive/release takes effect 4 clk after the scl falling pin edge. Initiator setup margin comes from the ≥4-clk low-phase rule.
- wr_valid is asserted in the cycle after the 8th WDATA rising edge is detected. The memory write lands in the same cycle, so a read of that byte in the same transaction returns the new value.
- A START and STOP cannot coincide. If a START is detected in the same cycle as a bit sample (glitchy initiator), the START wins and the sample is dropped.
- The ACK low window covers exactly one scl high phase (the 9th clock).

## Test plan
- **Single write.** Send START, 0x78, 0x30, 0x08, 0x82, STOP.
  - SDA is low at the 9th clock of all 4 bytes.
  - Exactly one wr_valid, with wr_addr=0x3008 and wr_data=0x82.
  - busy falls 3 clk after STOP.
- **Burst write with wrap.** Write 0x11, 0x22, 0x33 starting at 0x303F.
  - wr_valid three times, with wr_addr 0x303F, 0x3040, 0x3041.
  - mem indices 0x3F, 0x00, 0x01 hold 0x11, 0x22, 0x33.
- **Random read.** Send 0x78, 0x30, 0x08, then Sr, 0x79, read 2 bytes with ACK then NACK, then STOP.
  - Returned bytes are 0x82 then mem[0x09].
  - SDA is released after the NACK.
  - No wr_valid.
- **Wrong address.** Send START, 0x42, 0x00, 0x00, 0x55, STOP.
  - SDA is never driven low.
  - No wr_valid; memory is unchanged.
  - The next 0x78 transaction is ACKed normally.
- **STOP mid-byte.** Send STOP after 4 data bits of a WDATA byte.
  - No wr_valid; the target returns to IDLE.
  - A following full write to 0x3008 succeeds.
- **Reset mid-read.** Assert rst_n=0 while the target drives SDA low in RDATA.
  - SDA goes to z within the same cycle.
  - All outputs take reset values; a read of 0x3008 afterwards returns 0x00.
